// File: rtl/simple_bus_pkg.sv
// Shared types and limits for the simple_bus valid/ready skid stage.
// Optional parity is enabled by defining SIMPLE_BUS_PARITY_EN.
package simple_bus_pkg;

  localparam int unsigned WIDTH_MAX = 1024;

  typedef logic [31:0] width_t;
  typedef logic [15:0] cnt_t;

  function automatic width_t to_width(input int unsigned w);
    return width_t'(w);
  endfunction

endpackage

// File: rtl/simple_bus_skid.sv
// Two-entry main/skid register pair; s_ready_o comes straight from a flop,
// so there is no combinational path from m_ready_i back to upstream.
module simple_bus_skid #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  input  logic [DW-1:0] s_data_i,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [DW-1:0] m_data_o
);

  logic          main_valid_q, main_valid_d;
  logic [DW-1:0] main_data_q, main_data_d;
  logic          skid_valid_q, skid_valid_d;
  logic [DW-1:0] skid_data_q, skid_data_d;
  logic          accept;
  logic          xfer;

  assign s_ready_o = !skid_valid_q;
  assign m_valid_o = main_valid_q;
  assign m_data_o  = main_data_q;

  assign accept = s_valid_i && !skid_valid_q;
  assign xfer   = main_valid_q && m_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (xfer) begin
      // Skid refills main first; upstream is stalled while skid is full.
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_data_d = s_data_i;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_valid_d = 1'b1;
        skid_data_d  = s_data_i;
      end else begin
        main_valid_d = 1'b1;
        main_data_d  = s_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/simple_bus.sv
// Registered valid/ready stage with transfer counter and width query.
// Define SIMPLE_BUS_PARITY_EN to carry even parity and flag bad beats.
module simple_bus
  import simple_bus_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
`ifdef SIMPLE_BUS_PARITY_EN
  input  logic             s_par,
  output logic             m_par,
  output logic             par_err,
`endif
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output width_t           width_o,
  output cnt_t             xfer_cnt
);

`ifdef SIMPLE_BUS_PARITY_EN
  localparam int unsigned DW = WIDTH + 1;
`else
  localparam int unsigned DW = WIDTH;
`endif

  logic [DW-1:0] s_word;
  logic [DW-1:0] m_word;
  logic          xfer;
  cnt_t          cnt_q, cnt_d;

  assign width_o = to_width(WIDTH);

`ifdef SIMPLE_BUS_PARITY_EN
  // Parity bit rides alongside the payload through both registers.
  assign s_word = {s_par, s_data};
  assign {m_par, m_data} = m_word;
`else
  assign s_word = s_data;
  assign m_data = m_word;
`endif

  simple_bus_skid #(
    .DW(DW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .s_valid_i(s_valid),
    .s_ready_o(s_ready),
    .s_data_i (s_word),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready),
    .m_data_o (m_word)
  );

  assign xfer = m_valid && m_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (xfer) begin
      cnt_d = cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;

`ifdef SIMPLE_BUS_PARITY_EN
  logic par_err_q, par_err_d;
  logic accept;

  assign accept = s_valid && s_ready;

  always_comb begin
    par_err_d = par_err_q;
    if (accept && (s_par != ^s_data)) begin
      par_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_simple_bus.sv
// Self-checking bench for simple_bus: vector table, directed corner
// sequences and a queue-based reference model under random traffic.
module tb_simple_bus;
  import simple_bus_pkg::*;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  width_t      width_o;
  cnt_t        xfer_cnt;

  logic        s_valid2;
  logic        s_ready2;
  logic [31:0] s_data2;
  logic        m_valid2;
  logic        m_ready2;
  logic [31:0] m_data2;
  width_t      width_o2;
  cnt_t        xfer_cnt2;

`ifdef SIMPLE_BUS_PARITY_EN
  logic s_par, m_par, par_err;
  logic s_par2, m_par2, par_err2;
`endif

  int checks = 0;
  int errors = 0;

  simple_bus #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
`ifdef SIMPLE_BUS_PARITY_EN
    .s_par   (s_par),
    .m_par   (m_par),
    .par_err (par_err),
`endif
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .width_o (width_o),
    .xfer_cnt(xfer_cnt)
  );

  simple_bus #(.WIDTH(32)) dut32 (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid2),
    .s_ready (s_ready2),
    .s_data  (s_data2),
`ifdef SIMPLE_BUS_PARITY_EN
    .s_par   (s_par2),
    .m_par   (m_par2),
    .par_err (par_err2),
`endif
    .m_valid (m_valid2),
    .m_ready (m_ready2),
    .m_data  (m_data2),
    .width_o (width_o2),
    .xfer_cnt(xfer_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sv;
    logic [7:0] d;
    logic       mr;
    logic       ev;
    logic       cd;
    logic [7:0] ed;
    logic       er;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [7:0] d,
                       input logic mr);
    s_valid = sv;
    s_data  = d;
    m_ready = mr;
`ifdef SIMPLE_BUS_PARITY_EN
    s_par = ^d;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("rst_width8", width_o, 32'd8);
    chk("rst_width32", width_o2, 32'd32);
    chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_s_ready", {31'b0, s_ready}, 32'd1);
    chk("rst_m_data", {24'b0, m_data}, 32'd0);
    chk("rst_xfer_cnt", {16'b0, xfer_cnt}, 32'd0);
`ifdef SIMPLE_BUS_PARITY_EN
    chk("rst_par_err", {31'b0, par_err}, 32'd0);
`endif
    rst = 1'b0;
  endtask

  logic [7:0] q[$];
  cnt_t       mcnt;
  int         n;

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    s_valid2 = 1'b0;
    s_data2  = '0;
    m_ready2 = 1'b0;
`ifdef SIMPLE_BUS_PARITY_EN
    s_par2 = 1'b0;
`endif

    // Vector table: inputs driven this cycle, outputs expected before them.
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[1] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1};
    tbl[2] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
    tbl[3] = '{1'b0, 8'h77, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1};
    tbl[5] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[6] = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1};
    tbl[7] = '{1'b0, 8'h33, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("tbl%0d_m_valid", i), {31'b0, m_valid},
          {31'b0, tbl[i].ev});
      chk($sformatf("tbl%0d_s_ready", i), {31'b0, s_ready},
          {31'b0, tbl[i].er});
      if (tbl[i].cd)
        chk($sformatf("tbl%0d_m_data", i), {24'b0, m_data},
            {24'b0, tbl[i].ed});
      drive(tbl[i].sv, tbl[i].d, tbl[i].mr);
    end
    @(negedge clk);
    chk("tbl_xfer_cnt", {16'b0, xfer_cnt}, 32'd4);

    // Back-to-back stream with downstream always ready.
    do_reset();
    drive(1'b1, 8'h01, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("stream_m_valid", {31'b0, m_valid}, 32'd1);
      chk("stream_m_data", {24'b0, m_data}, 32'(i));
      chk("stream_s_ready", {31'b0, s_ready}, 32'd1);
      if (i < 16) drive(1'b1, 8'(i + 1), 1'b1);
      else drive(1'b0, 8'h00, 1'b1);
    end
    @(negedge clk);
    chk("stream_end_valid", {31'b0, m_valid}, 32'd0);
    chk("stream_xfer_cnt", {16'b0, xfer_cnt}, 32'd16);

    // Random traffic against a FIFO-of-two reference model.
    do_reset();
    q.delete();
    mcnt = '0;
    for (int i = 0; i < 3000; i++) begin
      logic r, sv, mr, acc, xf;
      logic [7:0] d;
      @(negedge clk);
      chk("rnd_m_valid", {31'b0, m_valid}, {31'b0, q.size() > 0});
      chk("rnd_s_ready", {31'b0, s_ready}, {31'b0, q.size() < 2});
      if (q.size() > 0)
        chk("rnd_m_data", {24'b0, m_data}, {24'b0, q[0]});
      chk("rnd_xfer_cnt", {16'b0, xfer_cnt}, {16'b0, mcnt});
      r  = ($urandom_range(0, 99) == 0);
      sv = ($urandom_range(0, 3) != 0);
      mr = ($urandom_range(0, 2) != 0);
      d  = 8'($urandom);
      rst = r;
      drive(sv, d, mr);
      if (r) begin
        q.delete();
        mcnt = '0;
      end else begin
        acc = sv && (q.size() < 2);
        xf  = (q.size() > 0) && mr;
        if (xf) begin
          void'(q.pop_front());
          mcnt = mcnt + 16'd1;
        end
        if (acc) q.push_back(d);
      end
    end
    @(negedge clk);
    rst = 1'b0;

    // Reset while both registers are occupied.
    do_reset();
    drive(1'b1, 8'hAA, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'hBB, 1'b0);
    @(negedge clk);
    chk("full_s_ready", {31'b0, s_ready}, 32'd0);
    chk("full_m_data", {24'b0, m_data}, 32'hAA);
    rst = 1'b1;
    drive(1'b1, 8'hCC, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    chk("full_rst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("full_rst_s_ready", {31'b0, s_ready}, 32'd1);
    chk("full_rst_m_data", {24'b0, m_data}, 32'd0);
    chk("full_rst_cnt", {16'b0, xfer_cnt}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("full_stale_m_valid", {31'b0, m_valid}, 32'd0);
      chk("full_stale_cnt", {16'b0, xfer_cnt}, 32'd0);
    end

`ifdef SIMPLE_BUS_PARITY_EN
    do_reset();
    drive(1'b1, 8'h03, 1'b1);
    s_par = 1'b1;
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b1);
    chk("par_bad_err", {31'b0, par_err}, 32'd1);
    chk("par_bad_m_par", {31'b0, m_par}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("par_sticky", {31'b0, par_err}, 32'd1);
    end
    do_reset();
    drive(1'b1, 8'h03, 1'b1);
    s_par = 1'b0;
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b1);
    chk("par_ok_err", {31'b0, par_err}, 32'd0);
    chk("par_ok_m_par", {31'b0, m_par}, 32'd0);
    chk("par_ok_m_valid", {31'b0, m_valid}, 32'd1);
    @(negedge clk);
    chk("par_ok_err2", {31'b0, par_err}, 32'd0);
`endif

    // Counter wrap: stream until 0xFFFF, then one more transfer.
    do_reset();
    drive(1'b1, 8'h00, 1'b1);
    n = 0;
    while (xfer_cnt != 16'hFFFF && n < 70000) begin
      @(negedge clk);
      n++;
      drive(1'b1, 8'(s_data + 8'd1), 1'b1);
    end
    chk("wrap_cycles", 32'(n), 32'd65536);
    drive(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk("wrap_cnt", {16'b0, xfer_cnt}, 32'd0);
    chk("wrap_m_valid", {31'b0, m_valid}, 32'd0);
    chk("wrap_width32", width_o2, 32'd32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
